// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage between Execute and WriteBack.
// Loads and stores go through a valid/ready request channel and a response-valid
// return channel. The stage aligns byte lanes, sign- or zero-extends load data and
// times out responses that never arrive. Non-memory ops reach WB one cycle after accept.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned loads and
// stores are trapped. When it is not defined, misaligned accesses are forced to natural
// alignment.
module mem_stage_lsu #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // Execute side
    input  logic                  i_ex_valid,
    output logic                  o_ex_ready,
    input  logic [XLEN-1:0]       i_result,
    input  logic [XLEN-1:0]       i_data_store,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [2:0]            i_func3,
    input  logic [4:0]            i_rd,
    input  logic [6:0]            i_opcode,
    // WriteBack side
    output logic                  o_mem_vld,
    output logic [4:0]            o_wb_rd,
    output logic [6:0]            o_opcode,
    output logic [XLEN-1:0]       o_wb_data,
    output logic                  o_bus_err,
    output logic                  o_misalign,
    // Data-memory bus
    output logic                  o_req_vld,
    input  logic                  i_req_rdy,
    output logic                  o_wr_en,
    output logic [XLEN/8-1:0]     o_sel,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [XLEN-1:0]       o_wdata,
    input  logic                  i_rsp_vld,
    input  logic [XLEN-1:0]       i_rdata
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // The last count value before a silent response is declared a bus error.
    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Holding registers for the access in flight
    logic                  wr_en_reg;
    logic [LANES-1:0]      sel_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [XLEN-1:0]       wdata_reg;
    logic [OFFW-1:0]       off_reg;
    logic [2:0]            func3_reg;
    logic [4:0]            rd_reg;
    logic [6:0]            opcode_reg;
    logic [TW-1:0]         cnt_reg;

    // Registered write-back outputs
    logic                  mem_vld_reg;
    logic [4:0]            wb_rd_reg;
    logic [6:0]            opcode_out_reg;
    logic [XLEN-1:0]       wb_data_reg;
    logic                  bus_err_reg;
    logic                  misalign_reg;

    // Decode of the incoming instruction
    logic                  accept;
    logic                  is_mem;
    logic                  is_jump;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [OFFW-1:0]       off_in;
    logic [OFFW-1:0]       size_mask;
    logic [OFFW-1:0]       eff_off;
    logic [LANES-1:0]      byte_mask;
    logic [LANES-1:0]      sel_calc;
    logic [XLEN-1:0]       wdata_calc;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       load_shift;
    logic [XLEN-1:0]       load_ext;
    logic                  timeout_hit;

    assign accept  = i_ex_valid && (state_reg == IDLE);
    assign is_mem  = (i_opcode == OP_LOAD) || (i_opcode == OP_STORE);
    assign is_jump = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);
    assign addr_in = ADDR_WIDTH'(i_result);
    assign off_in  = addr_in[OFFW-1:0];
    assign pc_plus4 = XLEN'(i_pc + ADDR_WIDTH'(4));

    // Access size: low-offset mask, lane mask and store-data replication
    always_comb begin
        size_mask  = '0;
        byte_mask  = '0;
        wdata_calc = i_data_store;
        case (i_func3[1:0])
            2'd0: begin
                size_mask  = '0;
                byte_mask  = LANES'(1);
                wdata_calc = {LANES{i_data_store[7:0]}};
            end
            2'd1: begin
                size_mask  = OFFW'(1);
                byte_mask  = LANES'(3);
                wdata_calc = {(LANES/2){i_data_store[15:0]}};
            end
            2'd2: begin
                size_mask  = OFFW'(3);
                byte_mask  = LANES'(15);
                wdata_calc = {(LANES/4){i_data_store[31:0]}};
            end
            default: begin
                size_mask  = OFFW'(7);
                byte_mask  = LANES'(255);
                wdata_calc = i_data_store;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // A misaligned memory access is reported to WB instead of reaching the bus.
    assign misaligned = is_mem && ((off_in & size_mask) != '0);
    assign eff_off    = off_in;
`else
    // Misaligned offsets are rounded down to the access size. No trap is raised.
    assign misaligned = 1'b0;
    assign eff_off    = off_in & ~size_mask;
`endif

    assign sel_calc = byte_mask << eff_off;

    // Load path: bring the addressed lane down to bit 0, then extend by func3
    assign load_shift = i_rdata >> {off_reg, 3'b000};

    // Sign- or zero-extension of the load data selected by func3
    always_comb begin
        load_ext = load_shift;
        case (func3_reg)
            3'b000:  load_ext = XLEN'($signed(load_shift[7:0]));
            3'b001:  load_ext = XLEN'($signed(load_shift[15:0]));
            3'b010:  load_ext = XLEN'($signed(load_shift[31:0]));
            3'b100:  load_ext = XLEN'(load_shift[7:0]);
            3'b101:  load_ext = XLEN'(load_shift[15:0]);
            3'b110:  load_ext = XLEN'(load_shift[31:0]);
            default: load_ext = load_shift;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> REQ -> RSP -> IDLE for bus accesses
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_mem && !misaligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (i_req_rdy) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (i_rsp_vld || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted op, run the response timer and build the WB pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg      <= 1'b0;
            sel_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            off_reg        <= '0;
            func3_reg      <= '0;
            rd_reg         <= '0;
            opcode_reg     <= '0;
            cnt_reg        <= '0;
            mem_vld_reg    <= 1'b0;
            wb_rd_reg      <= '0;
            opcode_out_reg <= '0;
            wb_data_reg    <= '0;
            bus_err_reg    <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            mem_vld_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
            misalign_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        wr_en_reg  <= (i_opcode == OP_STORE);
                        sel_reg    <= sel_calc;
                        addr_reg   <= {addr_in[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        wdata_reg  <= wdata_calc;
                        off_reg    <= eff_off;
                        func3_reg  <= i_func3;
                        rd_reg     <= i_rd;
                        opcode_reg <= i_opcode;
                        if (!is_mem || misaligned) begin
                            mem_vld_reg    <= 1'b1;
                            misalign_reg   <= misaligned;
                            wb_rd_reg      <= i_rd;
                            opcode_out_reg <= i_opcode;
                            if (misaligned) begin
                                wb_data_reg <= XLEN'(addr_in);
                            end else if (is_jump) begin
                                wb_data_reg <= pc_plus4;
                            end else begin
                                wb_data_reg <= i_result;
                            end
                        end
                    end
                end
                REQ: begin
                    if (i_req_rdy) begin
                        cnt_reg <= '0;
                    end
                end
                RSP: begin
                    cnt_reg <= cnt_reg + TW'(1);
                    if (i_rsp_vld) begin
                        mem_vld_reg    <= 1'b1;
                        wb_rd_reg      <= rd_reg;
                        opcode_out_reg <= opcode_reg;
                        wb_data_reg    <= wr_en_reg ? '0 : load_ext;
                    end else if (timeout_hit) begin
                        mem_vld_reg    <= 1'b1;
                        bus_err_reg    <= 1'b1;
                        wb_rd_reg      <= rd_reg;
                        opcode_out_reg <= opcode_reg;
                        wb_data_reg    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ex_ready = (state_reg == IDLE);
    assign o_req_vld  = (state_reg == REQ);
    assign o_wr_en    = wr_en_reg;
    assign o_sel      = sel_reg;
    assign o_addr     = addr_reg;
    assign o_wdata    = wdata_reg;
    assign o_mem_vld  = mem_vld_reg;
    assign o_wb_rd    = wb_rd_reg;
    assign o_opcode   = opcode_out_reg;
    assign o_wb_data  = wb_data_reg;
    assign o_bus_err  = bus_err_reg;
    assign o_misalign = misalign_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu (XLEN=32, TIMEOUT=8).
// Inputs change 1 ns after a rising edge. Outputs are checked at the same point.
module tb_mem_stage_lsu;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_ex_valid;
    logic            o_ex_ready;
    logic [XLEN-1:0] i_result;
    logic [XLEN-1:0] i_data_store;
    logic [AW-1:0]   i_pc;
    logic [2:0]      i_func3;
    logic [4:0]      i_rd;
    logic [6:0]      i_opcode;
    logic            o_mem_vld;
    logic [4:0]      o_wb_rd;
    logic [6:0]      o_opcode;
    logic [XLEN-1:0] o_wb_data;
    logic            o_bus_err;
    logic            o_misalign;
    logic            o_req_vld;
    logic            i_req_rdy;
    logic            o_wr_en;
    logic [3:0]      o_sel;
    logic [AW-1:0]   o_addr;
    logic [XLEN-1:0] o_wdata;
    logic            i_rsp_vld;
    logic [XLEN-1:0] i_rdata;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int hs_start;

    mem_stage_lsu #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
        .i_result(i_result), .i_data_store(i_data_store), .i_pc(i_pc),
        .i_func3(i_func3), .i_rd(i_rd), .i_opcode(i_opcode),
        .o_mem_vld(o_mem_vld), .o_wb_rd(o_wb_rd), .o_opcode(o_opcode),
        .o_wb_data(o_wb_data), .o_bus_err(o_bus_err), .o_misalign(o_misalign),
        .o_req_vld(o_req_vld), .i_req_rdy(i_req_rdy), .o_wr_en(o_wr_en),
        .o_sel(o_sel), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rsp_vld(i_rsp_vld), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    // Count bus handshakes seen at each rising edge
    always @(posedge clk) begin
        if (o_req_vld && i_req_rdy) hs_count = hs_count + 1;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd);
        i_ex_valid   = 1'b1;
        i_opcode     = op;
        i_func3      = f3;
        i_result     = res;
        i_data_store = sd;
        i_pc         = pc;
        i_rd         = rd;
    endtask

    initial begin
        rst = 1'b1; i_ex_valid = 1'b0; i_result = '0; i_data_store = '0; i_pc = '0;
        i_func3 = '0; i_rd = '0; i_opcode = '0; i_req_rdy = 1'b0; i_rsp_vld = 1'b0; i_rdata = '0;
        tick(); tick();
        $display("txn reset");
        chk("rst_ex_ready", 64'(o_ex_ready), 64'h1);
        chk("rst_mem_vld",  64'(o_mem_vld),  64'h0);
        chk("rst_req_vld",  64'(o_req_vld),  64'h0);
        chk("rst_wb_data",  64'(o_wb_data),  64'h0);
        chk("rst_sel",      64'(o_sel),      64'h0);
        chk("rst_flags",    64'({o_bus_err, o_misalign, o_wr_en}), 64'h0);
        rst = 1'b0;
        tick();

        // LB 0x1003, bus answers immediately
        $display("txn LB 0x1003");
        issue(7'b0000011, 3'b000, 32'h1003, 32'h0, 32'h0, 5'd5);
        i_req_rdy = 1'b1;
        tick();
        i_ex_valid = 1'b0;
        chk("lb_req_vld", 64'(o_req_vld), 64'h1);
        chk("lb_sel",     64'(o_sel),     64'h8);
        chk("lb_addr",    64'(o_addr),    64'h1000);
        chk("lb_wr_en",   64'(o_wr_en),   64'h0);
        chk("lb_ex_busy", 64'(o_ex_ready), 64'h0);
        tick();
        i_req_rdy = 1'b0;
        i_rsp_vld = 1'b1;
        i_rdata   = 32'h80123456;
        chk("lb_req_drop", 64'(o_req_vld), 64'h0);
        chk("lb_no_early", 64'(o_mem_vld), 64'h0);
        tick();
        i_rsp_vld = 1'b0;
        chk("lb_mem_vld", 64'(o_mem_vld), 64'h1);
        chk("lb_wb_data", 64'(o_wb_data), 64'hFFFFFF80);
        chk("lb_wb_rd",   64'(o_wb_rd),   64'h5);
        chk("lb_opcode",  64'(o_opcode),  64'h03);
        chk("lb_bus_err", 64'(o_bus_err), 64'h0);
        tick();
        chk("lb_pulse",   64'(o_mem_vld), 64'h0);
        chk("lb_idle",    64'(o_ex_ready), 64'h1);

        // SH 0x2002 with the bus stalling for 4 cycles
        $display("txn SH 0x2002 stall");
        hs_start = hs_count;
        issue(7'b0100011, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 5'd0);
        tick();
        i_ex_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data_store = 32'h5A5A0000 + 32'(k);
            chk("sh_req_vld", 64'(o_req_vld), 64'h1);
            chk("sh_sel",     64'(o_sel),     64'hC);
            chk("sh_wdata",   64'(o_wdata),   64'hBEEFBEEF);
            chk("sh_addr",    64'(o_addr),    64'h2000);
            chk("sh_wr_en",   64'(o_wr_en),   64'h1);
            tick();
        end
        i_req_rdy = 1'b1;
        chk("sh_wdata_hs", 64'(o_wdata), 64'hBEEFBEEF);
        tick();
        chk("sh_req_drop", 64'(o_req_vld), 64'h0);
        i_rsp_vld = 1'b1;
        tick();
        i_req_rdy = 1'b0;
        i_rsp_vld = 1'b0;
        chk("sh_mem_vld",  64'(o_mem_vld), 64'h1);
        chk("sh_wb_data",  64'(o_wb_data), 64'h0);
        chk("sh_one_hs",   64'(hs_count - hs_start), 64'h1);
        tick();

        // Back-to-back ADD then JAL
        $display("txn ADD+JAL");
        issue(7'b0110011, 3'b000, 32'h000055AA, 32'h0, 32'h0, 5'd7);
        tick();
        chk("add_mem_vld", 64'(o_mem_vld), 64'h1);
        chk("add_wb_data", 64'(o_wb_data), 64'h55AA);
        chk("add_wb_rd",   64'(o_wb_rd),   64'h7);
        chk("add_ready",   64'(o_ex_ready), 64'h1);
        issue(7'b1101111, 3'b000, 32'h0000DEAD, 32'h0, 32'h100, 5'd1);
        tick();
        i_ex_valid = 1'b0;
        chk("jal_mem_vld", 64'(o_mem_vld), 64'h1);
        chk("jal_wb_data", 64'(o_wb_data), 64'h104);
        chk("jal_wb_rd",   64'(o_wb_rd),   64'h1);
        chk("jal_ready",   64'(o_ex_ready), 64'h1);
        tick();
        chk("alu_idle",    64'(o_mem_vld), 64'h0);

        // LW never answered: bus error 8 cycles after entering RSP
        $display("txn LW timeout");
        issue(7'b0000011, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd9);
        i_req_rdy = 1'b1;
        tick();
        i_ex_valid = 1'b0;
        tick();
        i_req_rdy = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("to_wait", 64'(o_mem_vld), 64'h0);
        end
        tick();
        chk("to_mem_vld", 64'(o_mem_vld), 64'h1);
        chk("to_bus_err", 64'(o_bus_err), 64'h1);
        chk("to_wb_data", 64'(o_wb_data), 64'h0);
        tick();
        chk("to_clear",   64'(o_bus_err), 64'h0);
        chk("to_ready",   64'(o_ex_ready), 64'h1);

        // LW answered on the timeout cycle itself: response wins
        $display("txn LW late rsp");
        issue(7'b0000011, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd9);
        i_req_rdy = 1'b1;
        tick();
        i_ex_valid = 1'b0;
        tick();
        i_req_rdy = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        i_rsp_vld = 1'b1;
        i_rdata   = 32'h11223344;
        tick();
        i_rsp_vld = 1'b0;
        chk("late_mem_vld", 64'(o_mem_vld), 64'h1);
        chk("late_bus_err", 64'(o_bus_err), 64'h0);
        chk("late_wb_data", 64'(o_wb_data), 64'h11223344);
        tick();

        // LHU 0x5002: upper half, zero-extended
        $display("txn LHU 0x5002");
        issue(7'b0000011, 3'b101, 32'h5002, 32'h0, 32'h0, 5'd3);
        i_req_rdy = 1'b1;
        tick();
        i_ex_valid = 1'b0;
        chk("lhu_sel", 64'(o_sel), 64'hC);
        tick();
        i_req_rdy = 1'b0;
        i_rsp_vld = 1'b1;
        i_rdata   = 32'h9ABC0000;
        tick();
        i_rsp_vld = 1'b0;
        chk("lhu_wb_data", 64'(o_wb_data), 64'h9ABC);
        tick();

        // LW 0x1002: misaligned word
        $display("txn LW 0x1002 misaligned");
        issue(7'b0000011, 3'b010, 32'h1002, 32'h0, 32'h0, 5'd4);
        tick();
        i_ex_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req_vld",  64'(o_req_vld),  64'h0);
        chk("mis_mem_vld",  64'(o_mem_vld),  64'h1);
        chk("mis_flag",     64'(o_misalign), 64'h1);
        chk("mis_wb_data",  64'(o_wb_data),  64'h1002);
        chk("mis_ready",    64'(o_ex_ready), 64'h1);
        tick();
`else
        chk("mis_req_vld",  64'(o_req_vld),  64'h1);
        chk("mis_addr",     64'(o_addr),     64'h1000);
        chk("mis_sel",      64'(o_sel),      64'hF);
        chk("mis_flag",     64'(o_misalign), 64'h0);
        i_req_rdy = 1'b1;
        tick();
        i_req_rdy = 1'b0;
        i_rsp_vld = 1'b1;
        i_rdata   = 32'hCAFEF00D;
        tick();
        i_rsp_vld = 1'b0;
        chk("mis_wb_data",  64'(o_wb_data),  64'hCAFEF00D);
        chk("mis_no_trap",  64'(o_misalign), 64'h0);
        tick();
`endif

        // Reset while the request is pending, then a stray response
        $display("txn reset in REQ");
        issue(7'b0000011, 3'b100, 32'h4001, 32'h0, 32'h0, 5'd6);
        tick();
        i_ex_valid = 1'b0;
        chk("rr_req_vld", 64'(o_req_vld), 64'h1);
        rst = 1'b1;
        tick();
        chk("rr_req_drop", 64'(o_req_vld), 64'h0);
        rst = 1'b0;
        i_rsp_vld = 1'b1;
        i_rdata   = 32'hFFFFFFFF;
        tick();
        i_rsp_vld = 1'b0;
        chk("rr_no_vld", 64'(o_mem_vld), 64'h0);
        chk("rr_ready",  64'(o_ex_ready), 64'h1);
        tick();
        chk("rr_quiet",  64'(o_mem_vld), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
